data_mem_responder: RTL and testbench

Memory-side responder for the multicycle RV32I core: accepts one load/store/fetch request at a time from the core's control path, applies a fixed number of wait states, performs byte/half/word access on an internal word-organised array, and returns one response pulse. It is the slave end of the request protocol that the control unit drives during FETCH and MEM. Loads are sign- or zero-extended. Misaligned or out-of-range accesses are flagged, not performed.

---
 rtl/be_pkg.sv | 23 ++
 rtl/mem_word_array.sv | 33 +++
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/be_pkg.sv
// Shared types for the data memory responder.
//   mem_rsp_state_t : responder FSM states
//   mem_size_t      : RV32I load/store funct3 encodings
//   MEM_WAIT_CNT_W  : width of the wait-state counter (supports 0..15)
package be_pkg;

  localparam int MEM_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_rsp_state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: DEPTH_WORDS x 32, synchronous write with per-byte
// enables, registered read. Contents are not reset.
//   clk      : clock
//   wr_en    : write strobe, wr_be selects lanes, wr_idx word index
//   wr_data  : lane-aligned write data
//   rd_en    : read strobe, rd_idx word index
//   rd_data  : registered read word (holds while rd_en low)
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem[wr_idx][l] <= wr_data[8*l +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the multicycle RV32I core. Accepts one request
// in IDLE, waits WAIT_STATES cycles, commits the access on the edge entering
// RESP and pulses rsp_valid for one cycle. Errors suppress the write and
// return zero data.
//   clk, rst                 : clock, async active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we/size/addr/wdata   : request fields, sampled at acceptance
//   rsp_valid/rsp_rdata/err  : one-cycle response; data/err hold afterwards
module data_mem_responder
  import be_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [MEM_WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? MEM_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  function automatic logic req_bad(logic we, logic [2:0] sz, logic [31:0] a);
    logic bad;
    case (sz)
      SZ_B:  bad = 1'b0;
      SZ_H:  bad = a[0];
      SZ_W:  bad = |a[1:0];
      SZ_BU: bad = we;
      SZ_HU: bad = we | a[0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] st_be(logic [2:0] sz, logic [1:0] a);
    case (sz)
      SZ_B:    st_be = 4'b0001 << a;
      SZ_H:    st_be = a[1] ? 4'b1100 : 4'b0011;
      default: st_be = 4'b1111;
    endcase
  endfunction

  // Replicate narrow data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] st_dat(logic [2:0] sz, logic [31:0] d);
    case (sz)
      SZ_B:    st_dat = {4{d[7:0]}};
      SZ_H:    st_dat = {2{d[15:0]}};
      default: st_dat = d;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(logic [2:0] sz, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    ld_ext = {{24{b[7]}}, b};
      SZ_H:    ld_ext = {{16{h[15]}}, h};
      SZ_BU:   ld_ext = {24'b0, b};
      SZ_HU:   ld_ext = {16'b0, h};
      default: ld_ext = w;
    endcase
  endfunction

  mem_rsp_state_t            state;
  logic [MEM_WAIT_CNT_W-1:0] cnt;
  logic                      rdy;
  logic                      we_q, err_q, err_hold;
  logic [2:0]                size_q;
  logic [AW+1:0]             addr_q;
  logic [31:0]               wdata_q, rdata_hold, rd_data, rsp_now;
  logic                      accept, err_in;
  logic                      wr_en;
  logic [3:0]                wr_be;
  logic [AW-1:0]             wr_idx;
  logic [31:0]               wr_data;

  assign accept = req_valid & rdy;
  assign err_in = req_bad(req_we, req_size, req_addr);

  // With no wait states the edge entering RESP is the acceptance edge, so the
  // write comes straight from the request inputs; otherwise from the captured
  // request on the last WAIT cycle.
  always_comb begin
    if (WAIT_STATES == 0) begin
      wr_en   = accept & req_we & ~err_in;
      wr_idx  = req_addr[AW+1:2];
      wr_be   = st_be(req_size, req_addr[1:0]);
      wr_data = st_dat(req_size, req_wdata);
    end else begin
      wr_en   = (state == WAIT) & (cnt == '0) & we_q & ~err_q;
      wr_idx  = addr_q[AW+1:2];
      wr_be   = st_be(size_q, addr_q[1:0]);
      wr_data = st_dat(size_q, wdata_q);
    end
  end

  // Read is launched at acceptance and held, so the word is ready by RESP
  // for any WAIT_STATES value.
  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_arr (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_idx  (req_addr[AW+1:2]),
    .rd_data (rd_data)
  );

  assign rsp_now   = (err_q | we_q) ? 32'b0 : ld_ext(size_q, addr_q[1:0], rd_data);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rsp_now : rdata_hold;
  assign rsp_err   = rsp_valid ? err_q   : err_hold;
  assign req_ready = rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdy        <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_hold <= '0;
      err_hold   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            err_q   <= err_in;
            rdy     <= 1'b0;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= RESP;
            end
          end else begin
            rdy <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          state      <= IDLE;
          rdy        <= 1'b1;
          rdata_hold <= rsp_now;
          err_hold   <= err_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import be_pkg::*;

  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // m_: WAIT_STATES=1, z_: WAIT_STATES=0, t_: WAIT_STATES=3
  logic        m_req_valid, m_req_ready, m_req_we, m_rsp_valid, m_rsp_err;
  logic [2:0]  m_req_size;
  logic [31:0] m_req_addr, m_req_wdata, m_rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_err;
  logic [2:0]  z_req_size;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic        t_req_valid, t_req_ready, t_req_we, t_rsp_valid, t_rsp_err;
  logic [2:0]  t_req_size;
  logic [31:0] t_req_addr, t_req_wdata, t_rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(1)) u_m (
    .clk(clk), .rst(rst), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_we(m_req_we), .req_size(m_req_size), .req_addr(m_req_addr),
    .req_wdata(m_req_wdata), .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata),
    .rsp_err(m_rsp_err));

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_size(z_req_size), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err));

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(3)) u_t (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_we(t_req_we), .req_size(t_req_size), .req_addr(t_req_addr),
    .req_wdata(t_req_wdata), .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
    .rsp_err(t_rsp_err));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT_STATES=1 instance; checks latency and response.
  // Inputs are scrambled after acceptance to show they are not re-sampled.
  task automatic m_xact(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    int n;
    m_req_valid = 1'b1; m_req_we = we; m_req_size = sz;
    m_req_addr = a; m_req_wdata = wd;
    n = 0;
    while (!m_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    m_req_valid = 1'b0; m_req_we = ~we; m_req_size = 3'b010;
    m_req_addr = ~a; m_req_wdata = ~wd;
    n = 1;
    while (!m_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " lat"}, n, 2);
    check({tag, " rdata"}, m_rsp_rdata, exp_d);
    check({tag, " err"}, m_rsp_err, exp_e);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int saw;
    m_req_valid = 0; m_req_we = 0; m_req_size = 0; m_req_addr = 0; m_req_wdata = 0;
    z_req_valid = 0; z_req_we = 0; z_req_size = 0; z_req_addr = 0; z_req_wdata = 0;
    t_req_valid = 0; t_req_we = 0; t_req_size = 0; t_req_addr = 0; t_req_wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst rsp_valid", m_rsp_valid, 0);
    check("rst rdata", m_rsp_rdata, 0);
    check("rst err", m_rsp_err, 0);
    check("rst ready", m_req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready after rst", m_req_ready, 1);

    // Basic word store/load and extensions
    m_xact("SW 10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    m_xact("LW 10",  0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    m_xact("LB 13",  0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    m_xact("LBU 13", 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
    m_xact("LH 10",  0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    m_xact("LHU 12", 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);

    // Partial stores keep the other lanes
    m_xact("SB 11",  1, 3'b000, 32'h11, 32'h0000005A, 32'h0, 0);
    m_xact("LW 10b", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 0);
    check("hold rdata", m_rsp_rdata, 32'hDEAD5AEF);
    check("hold no rsp", m_rsp_valid, 0);
    m_xact("SW 14",  1, 3'b010, 32'h14, 32'h0, 32'h0, 0);
    m_xact("SH 16",  1, 3'b001, 32'h16, 32'h0000A1B2, 32'h0, 0);
    m_xact("LW 14",  0, 3'b010, 32'h14, 32'h0, 32'hA1B20000, 0);
    m_xact("SW 0",   1, 3'b010, 32'h0, 32'h0BADF00D, 32'h0, 0);

    // Errors: nothing written, zero data
    m_xact("LW 12 mis",  0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
    m_xact("SH 13 mis",  1, 3'b001, 32'h13, 32'h0, 32'h0, 1);
    m_xact("LW oor",     0, 3'b010, DW*4, 32'h0, 32'h0, 1);
    m_xact("SW oor",     1, 3'b010, DW*4, 32'h0, 32'h0, 1);
    m_xact("S size100",  1, 3'b100, 32'h10, 32'h0, 32'h0, 1);
    m_xact("L size011",  0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    m_xact("LW 10 after err", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 0);
    m_xact("LW 0 after oor",  0, 3'b010, 32'h0, 32'h0, 32'h0BADF00D, 0);

    // Zero wait states, req_valid held high across back-to-back requests
    z_req_valid = 1; z_req_we = 1; z_req_size = 3'b010;
    z_req_addr = 32'h8; z_req_wdata = 32'h123480F5;
    check("W0 ready", z_req_ready, 1);
    @(posedge clk); #1;
    check("W0 SW rsp", z_rsp_valid, 1);
    check("W0 SW busy", z_req_ready, 0);
    z_req_we = 0; z_req_size = 3'b000;
    @(posedge clk); #1;
    check("W0 re-ready", z_req_ready, 1);
    check("W0 idle no rsp", z_rsp_valid, 0);
    @(posedge clk); #1;
    check("W0 LB rsp", z_rsp_valid, 1);
    check("W0 LB rdata", z_rsp_rdata, 32'hFFFFFFF5);
    z_req_size = 3'b101; z_req_addr = 32'hA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("W0 LHU rsp", z_rsp_valid, 1);
    check("W0 LHU rdata", z_rsp_rdata, 32'h00001234);
    z_req_valid = 0;

    // Three wait states
    t_req_valid = 1; t_req_we = 1; t_req_size = 3'b010;
    t_req_addr = 32'h4; t_req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    t_req_valid = 0;
    n = 1;
    while (!t_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("W3 SW lat", n, 4);
    @(posedge clk); #1;
    t_req_valid = 1; t_req_we = 0; t_req_size = 3'b010;
    @(posedge clk); #1;
    t_req_valid = 0;
    n = 1;
    while (!t_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("W3 LW lat", n, 4);
    check("W3 LW rdata", t_rsp_rdata, 32'hCAFEF00D);

    // Reset during WAIT drops the store
    m_xact("SW 20 pre", 1, 3'b010, 32'h20, 32'h11112222, 32'h0, 0);
    m_xact("LW 20 pre", 0, 3'b010, 32'h20, 32'h0, 32'h11112222, 0);
    m_req_valid = 1; m_req_we = 1; m_req_size = 3'b010;
    m_req_addr = 32'h20; m_req_wdata = 32'h12345678;
    @(posedge clk); #1;
    m_req_valid = 0;
    check("midrst busy", m_req_ready, 0);
    rst = 1'b0;
    #1;
    check("midrst rsp_valid", m_rsp_valid, 0);
    check("midrst rdata", m_rsp_rdata, 0);
    check("midrst err", m_rsp_err, 0);
    check("midrst ready", m_req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    saw = 0;
    repeat (4) begin @(posedge clk); #1; if (m_rsp_valid) saw++; end
    check("midrst no rsp", saw, 0);
    m_xact("LW 20 post", 0, 3'b010, 32'h20, 32'h0, 32'h11112222, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
